// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
//   spi_state_e : slave FSM states
//   OP_*        : RAM command opcodes carried in rx_data[ADDR_SIZE+1:ADDR_SIZE]
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_piso_tx.sv
// Parallel-in serial-out transmitter driving MISO, MSB first.
//   clk, rst_n : clock, async active-low reset
//   load       : capture data and present its MSB on miso at this edge
//   abort      : drop any transmit in progress, miso low next edge
//   data       : word to transmit
//   miso       : registered serial output, low whenever not shifting
module spi_piso_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] data,
  output logic             miso
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  left_q, left_d;
  logic             miso_q, miso_d;

  always_comb begin
    sr_d   = sr_q;
    left_d = left_q;
    miso_d = 1'b0;
    if (abort) begin
      left_d = '0;
    end else if (load) begin
      // MSB goes out immediately; the rest waits in the shift register.
      miso_d = data[WIDTH-1];
      sr_d   = data << 1;
      left_d = CntW'(WIDTH - 1);
    end else if (left_q != '0) begin
      miso_d = sr_q[WIDTH-1];
      sr_d   = sr_q << 1;
      left_d = left_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      left_q <= '0;
      miso_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      left_q <= left_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front-end for the SPI/RAM wrapper.
//   clk, rst_n : clock (all logic on posedge), async active-low reset
//   SS_n       : slave select, active low, frames a transaction
//   MOSI       : serial command/payload in, MSB first
//   MISO       : serial read data out, MSB first, registered
//   rx_data    : command word to RAM {opcode, payload}, held until next complete frame
//   rx_valid   : one-cycle strobe per complete frame
//   tx_data    : RAM read data
//   tx_valid   : RAM read data valid
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int unsigned FrameW = ADDR_SIZE + 2;
  localparam int unsigned CntW   = $clog2(ADDR_SIZE + 3);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameW);

  spi_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // Last payload bit comes straight from MOSI, so only FrameW-1 bits are stored.
  logic [FrameW-2:0]   shift_q, shift_d;
  logic [FrameW-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  // Set once read data has been loaded in this frame; later tx_valid is ignored.
  logic                tx_busy_q, tx_busy_d;
  logic                tx_load;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_busy_d      = tx_busy_q;
    tx_load        = 1'b0;

    if (SS_n) begin
      state_d   = IDLE;
      cnt_d     = '0;
      tx_busy_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q != CntFull) begin
            shift_d = {shift_q[FrameW-3:0], MOSI};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              rx_data_d  = {shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
            end
          end else if (state_q == READ_DATA && tx_valid && !tx_busy_q) begin
            tx_load   = 1'b1;
            tx_busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_busy_q      <= tx_busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  spi_piso_tx #(
    .WIDTH(ADDR_SIZE)
  ) u_piso_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tx_load),
    .abort(SS_n),
    .data (tx_data),
    .miso (MISO)
  );

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Randomized self-checking bench for spi_slave_fsm (MEM_DEPTH=256).
module tb_spi_slave_fsm;
  import spi_pkg::*;

  localparam int A  = 8;
  localparam int FW = A + 2;
  localparam int T  = FW + 3;  // edge index at which RAM answers a read

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [A-1:0]  tx_data = '0;
  logic          tx_valid = 1'b0;

  spi_slave_fsm #(
    .MEM_DEPTH(256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: protocol-level memory of the slave.
  bit            m_seen = 1'b0;
  logic [FW-1:0] m_rx   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One SS_n-low window: cmd bit, n_pay payload bits of word, then hold extra
  // cycles if the frame is complete. give_tx answers a read at edge T with txd.
  // rst_at >= 0 pulses rst_n right after that edge.
  task automatic run_frame(input logic cmd, input logic [FW-1:0] word, input int n_pay,
                           input int hold, input bit give_tx, input logic [A-1:0] txd,
                           input int rst_at);
    bit complete = (n_pay >= FW);
    bit is_rd    = cmd && m_seen;
    int edges    = complete ? (2 + FW + hold) : (2 + n_pay);
    bit stop     = 1'b0;
    bit exp_miso;
    bit noise_ok;
    for (int k = 0; k < edges && !stop; k++) begin
      @(negedge clk);
      SS_n = 1'b0;
      if (k == 1) MOSI = cmd;
      else if (k >= 2 && k - 2 < FW) MOSI = word[FW-1-(k-2)];
      else MOSI = 1'($urandom);
      noise_ok = !is_rd || (k <= FW + 1) || (give_tx && k > T);
      if (is_rd && give_tx && k == T) begin
        tx_valid = 1'b1;
        tx_data  = txd;
      end else begin
        tx_valid = noise_ok ? ($urandom_range(3) == 0) : 1'b0;
        tx_data  = A'($urandom);
      end
      @(posedge clk);
      #1;
      check_eq("rx_valid", 32'(rx_valid), 32'(complete && k == FW + 1));
      if (complete && k == FW + 1) check_eq("rx_data", 32'(rx_data), 32'(word));
      exp_miso = is_rd && give_tx && k >= T && k < T + A && txd[A-1-(k-T)];
      check_eq("miso", 32'(MISO), 32'(exp_miso));
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        m_seen = 1'b0;
        m_rx   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        stop  = 1'b1;
      end
    end
    if (!stop && complete) begin
      m_rx = word;
      if (cmd) m_seen = !m_seen;
    end
    @(negedge clk);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("idle_miso", 32'(MISO), 32'd0);
    check_eq("idle_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rx_data_hold", 32'(rx_data), 32'(m_rx));
    check_eq("rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'(m_seen));
  endtask

  initial begin
    logic [FW-1:0] w;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_miso", 32'(MISO), 32'd0);
    check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("reset_rx_data", 32'(rx_data), 32'd0);
    check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    run_frame(1'b0, {OP_WR_ADDR, 8'hA5}, FW, 2, 1'b0, 8'h00, -1);
    run_frame(1'b0, {OP_WR_DATA, 8'h3C}, FW, 3, 1'b1, 8'hFF, -1);
    run_frame(1'b1, {OP_RD_ADDR, 8'h33}, FW, 4, 1'b1, 8'h5A, -1);
    run_frame(1'b1, {OP_RD_DATA, 8'h00}, FW, 12, 1'b1, 8'hC3, -1);
    // Read-data opcode while no address seen: treated as READ_ADD, no MISO.
    run_frame(1'b1, {OP_RD_DATA, 8'h7E}, FW, 12, 1'b1, 8'hFF, -1);
    check_eq("rd_add_entered", 32'(m_seen), 32'd1);
    // Abort after 5 payload bits, then a full frame.
    run_frame(1'b0, {OP_WR_ADDR, 8'hFF}, 5, 0, 1'b0, 8'h00, -1);
    run_frame(1'b0, {OP_WR_DATA, 8'h81}, FW, 1, 1'b0, 8'h00, -1);
    // Read data aborted mid-shift by SS_n.
    run_frame(1'b1, {OP_RD_DATA, 8'h11}, FW, 5, 1'b1, 8'hAA, -1);

    // Random frames.
    for (int i = 0; i < 60; i++) begin
      w = FW'($urandom);
      run_frame(1'(($urandom_range(2) != 0) ? 1 : 0) ? 1'($urandom) : 1'b1, w,
                ($urandom_range(4) == 0) ? int'($urandom_range(FW - 1)) : FW,
                int'($urandom_range(14)), 1'($urandom_range(3) != 0), A'($urandom), -1);
    end

    // Reset during MISO shifting.
    if (!m_seen) run_frame(1'b1, {OP_RD_ADDR, 8'h42}, FW, 0, 1'b0, 8'h00, -1);
    run_frame(1'b1, {OP_RD_DATA, 8'h42}, FW, 12, 1'b1, 8'hE7, T + 3);
    run_frame(1'b0, {OP_WR_ADDR, 8'h5C}, FW, 2, 1'b0, 8'h00, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
